clkdiv_seq_ctrl: RTL
====================

// Module: clkdiv_seq_ctrl
// PURPOSE
//  Sequencer for the main-clock divider driven from the 1.2GHz PLL clock (ckin0).
//  - Generates the divided clock clkout with divide ratio K.
//  - Accepts K changes over a req/ack handshake.
//  - Applies a new K only at a period boundary, with a gated settle gap, so that
//    clkout never produces a runt pulse.
//  - Sits between the config/reg block and the main clock output.
// PARAMETERS
//  KW      5   width of divide ratio K
//  DEF_K   8   K loaded at reset (2..2**KW-1)
//  SETTLE  4   ckin0 cycles clkout is held low between old and new K (>=1)
// PORTS
//  ckin0    in   1   clock, 1.2GHz from PLL; all logic on rising edge
//  rst_n    in   1   asynchronous active-low reset
//  en       in   1   run divider (level)
//  cfg_req  in   1   request new K (level; hold until cfg_ack)
//  cfg_k    in   KW  requested K, stable while cfg_req=1
//  cfg_ack  out  1   1-cycle pulse: request completed (applied or rejected)
//  cfg_err  out  1   1-cycle pulse with cfg_ack: cfg_k<2, request rejected
//  clkout   out  1   divided clock, registered
//  busy     out  1   1 in DRAIN/GATED
//  k_cur    out  KW  ratio currently in effect
// BEHAVIOUR
//  Reset (async, any time, incl. mid-change):
//   - state=IDLE, k_cur=DEF_K, cnt=0, clkout=0, cfg_ack=0, cfg_err=0, busy=0.
//   - Any pending K is discarded.
//  Divider:
//   - cnt counts 0..k_cur-1, then wraps to 0.
//   - clkout=1 for cnt<H, H=k_cur-(k_cur>>1) (ceil), else 0.
//   - Period is exactly k_cur cycles.
//  States:
//   IDLE:
//    - clkout=0.
//    - en=1 at edge n -> RUN, cnt=0; clkout=1 after edge n+1.
//   RUN:
//    - en=0 -> DRAIN (stop pending).
//    - cfg_req=1 and cfg_k>=2 -> latch k_pend, DRAIN.
//    - cfg_req=1 and cfg_k<2 -> cfg_ack=cfg_err=1 for one cycle, stay RUN.
//   DRAIN:
//    - Keep counting.
//    - At cnt==k_cur-1 -> GATED (clkout=0), settle counter=SETTLE.
//   GATED:
//    - clkout=0 for SETTLE cycles.
//    - Then load k_cur=k_pend (if a change is pending), cnt=0, cfg_ack=1 for
//      one cycle.
//    - Next state RUN if en=1, else IDLE.
//  Handshake:
//   - cfg_req is sampled only in IDLE/RUN; ignored in DRAIN/GATED.
//   - In IDLE a valid req loads k_cur next edge with cfg_ack; no clock is
//     produced.
//   - Requester drops cfg_req the cycle after cfg_ack; if req is still high
//     one cycle after ack, it is a new request.
//   - en=0 and cfg_req on the same RUN cycle: change wins; after GATED -> IDLE.
//   - en toggles during DRAIN/GATED: sampled only at GATED exit.
//   - Max K (2**KW-1): cnt never overflows (KW bits).
// CONFIGURATION
//  CLKDIV_PWRDN_EN defined:
//   - Adds ports pd_req (in, 1) and pd_ack (out, 1).
//   - pd_req=1 in any state: finish current period as in DRAIN, then enter
//     PWRDN; clkout=0, pd_ack=1 (level) while in PWRDN.
//   - pd_req=0 -> IDLE next cycle, pd_ack=0.
//   - cfg_req is ignored in PWRDN.
//  Not defined:
//   - No extra ports; PWRDN state absent.
// TESTING
//  1. Reset, en=1, K=8 -> clkout 4 high/4 low, first rise 1 cycle after en;
//     k_cur=8.
//  2. RUN K=8, cfg_req K=5 at cnt=2 -> 5 more old cycles, 4 low cycles, then
//     3H/2L periods; single cfg_ack.
//  3. cfg_req K=1 -> cfg_ack+cfg_err same cycle, clkout period unchanged,
//     k_cur=8.
//  4. K=31 with en dropped mid-high phase -> period completes (16H/15L
//     intact), clkout stays 0, IDLE.
//  5. rst_n low during GATED -> clkout=0, k_cur=DEF_K immediately; no cfg_ack
//     after release.
//  6. CLKDIV_PWRDN_EN: pd_req in RUN K=6 -> period ends, pd_ack=1; release ->
//     IDLE, en=1 restarts at K=6.

Source files
------------

// File: rtl/clkdiv_seq_ctrl.sv
// clkdiv_seq_ctrl: runt-free divide-by-K clock sequencer with req/ack ratio change.
// Optional power-down handshake (pd_req/pd_ack) when CLKDIV_PWRDN_EN is defined.
module clkdiv_seq_ctrl #(
  parameter int KW     = 5,
  parameter int DEF_K  = 8,
  parameter int SETTLE = 4
) (
  input  logic          ckin0,
  input  logic          rst_n,
  input  logic          en,
  input  logic          cfg_req,
  input  logic [KW-1:0] cfg_k,
`ifdef CLKDIV_PWRDN_EN
  input  logic          pd_req,
  output logic          pd_ack,
`endif
  output logic          cfg_ack,
  output logic          cfg_err,
  output logic          clkout,
  output logic          busy,
  output logic [KW-1:0] k_cur
);
  localparam int SW = $clog2(SETTLE + 1);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, GATED
`ifdef CLKDIV_PWRDN_EN
    , PWRDN
`endif
  } state_e;
  state_e state_q, state_d;
  logic [KW-1:0] cnt_q, cnt_d, k_q, k_d, kp_q, kp_d, h;
  logic [SW-1:0] settle_q, settle_d;
  logic pend_q, pend_d, clk_q, clk_d, ack_q, ack_d, err_q, err_d;
  logic wrap, counting, samp, gate_done, req_ok, req_bad;
  assign h         = k_q - (k_q >> 1);
  assign wrap      = cnt_q == k_q - KW'(1);
  assign counting  = state_q == RUN || state_q == DRAIN;
  assign samp      = state_q == IDLE || state_q == RUN;
  assign gate_done = state_q == GATED && settle_q == SW'(1);
  // a request is not re-sampled while its own ack is still showing
  assign req_ok    = cfg_req && !ack_q && cfg_k >= KW'(2);
  assign req_bad   = cfg_req && !ack_q && cfg_k < KW'(2);
`ifdef CLKDIV_PWRDN_EN
  logic pds_q, pd_stop;
  assign pd_stop = pds_q | pd_req;
  always_ff @(posedge ckin0 or negedge rst_n)
    if (!rst_n) pds_q <= 1'b0;
    else pds_q <= (counting || state_q == GATED) && pd_stop;
`endif
  always_ff @(posedge ckin0 or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      k_q      <= KW'(DEF_K);
      kp_q     <= '0;
      settle_q <= '0;
      pend_q   <= 1'b0;
      clk_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      kp_q     <= kp_d;
      settle_q <= settle_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = en ? RUN : IDLE;
      RUN:     state_d = (req_ok || !en) ? (wrap ? GATED : DRAIN) : RUN;
      DRAIN:   state_d = wrap ? GATED : DRAIN;
      GATED:   state_d = gate_done ? (en ? RUN : IDLE) : GATED;
      default: state_d = IDLE;
    endcase
`ifdef CLKDIV_PWRDN_EN
    case (state_q)
      IDLE:    state_d = pd_req ? PWRDN : state_d;
      RUN:     state_d = pd_req ? (!wrap ? DRAIN : req_ok ? GATED : PWRDN) : state_d;
      DRAIN:   state_d = wrap && pd_stop && !pend_q ? PWRDN : state_d;
      GATED:   state_d = gate_done && pd_stop ? PWRDN : state_d;
      PWRDN:   state_d = pd_req ? PWRDN : IDLE;
      default: state_d = state_d;
    endcase
`endif
  end
  always_comb begin
    cnt_d    = counting && !wrap ? cnt_q + KW'(1) : '0;
    clk_d    = counting && cnt_q < h;
    settle_d = state_q == GATED ? settle_q - SW'(1) : SW'(SETTLE);
    k_d      = gate_done && pend_q ? kp_q : (state_q == IDLE && req_ok ? cfg_k : k_q);
    kp_d     = state_q == RUN && req_ok ? cfg_k : kp_q;
    pend_d   = state_q == RUN && req_ok ? 1'b1 : (gate_done ? 1'b0 : pend_q);
    ack_d    = (gate_done && pend_q) || (samp && req_bad) || (state_q == IDLE && req_ok);
    err_d    = samp && req_bad;
  end
  always_comb begin
    busy    = state_q == DRAIN || state_q == GATED;
    clkout  = clk_q;
    cfg_ack = ack_q;
    cfg_err = err_q;
    k_cur   = k_q;
`ifdef CLKDIV_PWRDN_EN
    pd_ack  = state_q == PWRDN;
`endif
  end
endmodule
